// File: rtl/lix_pkg.sv
// lix_pkg: shared definitions for the lix_* datapath library.
//   - LIX_DRN_* : state encodings for the lix_reg_drain skid buffer FSM
//   - LIX_RST_DATA_BIT : value every data register bit takes on reset
//   - lix_drn_cnt() : occupancy implied by a drain state
package lix_pkg;

  localparam logic [1:0] LIX_DRN_EMPTY = 2'd0;
  localparam logic [1:0] LIX_DRN_ONE   = 2'd1;
  localparam logic [1:0] LIX_DRN_FULL  = 2'd2;

  // Data registers reset to all zeros so o_z is never X after reset.
  localparam logic LIX_RST_DATA_BIT = 1'b0;

  // Occupancy is derived from the state alone, so it cannot exceed 2.
  function automatic logic [1:0] lix_drn_cnt(input logic [1:0] st);
    logic [1:0] cnt;
    case (st)
      LIX_DRN_EMPTY: cnt = 2'd0;
      LIX_DRN_ONE:   cnt = 2'd1;
      LIX_DRN_FULL:  cnt = 2'd2;
      default:       cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/lix_dff_en.sv
// lix_dff_en: W-bit enable flop with asynchronous active-high reset.
// Kept as its own module so the storage cell can be remapped per target
// library without touching the control logic that uses it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q
//   en   - load enable
//   d    - data in
//   q    - registered data out
module lix_dff_en
  import lix_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage register: load on enable, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{LIX_RST_DATA_BIT}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/lix_reg_drain.sv
// lix_reg_drain: 2-entry skid buffer between an enable-gated producer and a
// valid/ready consumer. Head slot H drives o_z; skid slot S catches a word
// only when H is occupied and not being popped.
// Ports:
//   clk_i   - clock, all state on rising edge
//   rst_i   - asynchronous active-high reset
//   i_vld   - upstream word valid
//   i_en    - upstream enable; word offered only when i_vld && i_en
//   i_x     - upstream data
//   o_rdy   - buffer can accept (registered)
//   i_flush - synchronous discard of all buffered words (highest priority)
//   o_vld   - head word valid (registered)
//   o_z     - head word data (registered, straight from H)
//   i_rdy   - downstream ready
//   o_cnt   - occupancy 0..2 (registered)
module lix_reg_drain
  import lix_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_vld,
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic         o_rdy,
  input  logic         i_flush,
  output logic         o_vld,
  output logic [W-1:0] o_z,
  input  logic         i_rdy,
  output logic [1:0]   o_cnt
);

  logic [1:0]   state_r;
  logic [1:0]   next_state_s;
  logic         push_s;
  logic         pop_s;
  logic         h_en_s;
  logic         s_en_s;
  logic [W-1:0] h_d_s;
  logic [W-1:0] s_q_s;
  logic         vld_nx_s;
  logic         rdy_nx_s;
  logic [1:0]   cnt_nx_s;

  // Handshakes use the registered flags, so there is no path i_rdy -> o_rdy.
  assign push_s = i_vld && i_en && o_rdy;
  assign pop_s  = o_vld && i_rdy;

  // State register plus flags registered from the next state, so the flags
  // describe the state in the same cycle it is entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= LIX_DRN_EMPTY;
      o_vld   <= 1'b0;
      o_rdy   <= 1'b1;
      o_cnt   <= 2'd0;
    end else begin
      state_r <= next_state_s;
      o_vld   <= vld_nx_s;
      o_rdy   <= rdy_nx_s;
      o_cnt   <= cnt_nx_s;
    end
  end

  // Next-state and slot-load decode; flush overrides any push or pop.
  always_comb begin
    next_state_s = state_r;
    h_en_s       = 1'b0;
    s_en_s       = 1'b0;
    h_d_s        = i_x;
    if (i_flush) begin
      next_state_s = LIX_DRN_EMPTY;
    end else begin
      case (state_r)
        LIX_DRN_EMPTY: begin
          if (push_s) begin
            h_en_s       = 1'b1;
            next_state_s = LIX_DRN_ONE;
          end else begin
            next_state_s = LIX_DRN_EMPTY;
          end
        end
        LIX_DRN_ONE: begin
          if (push_s && pop_s) begin
            h_en_s       = 1'b1;
            next_state_s = LIX_DRN_ONE;
          end else if (push_s) begin
            s_en_s       = 1'b1;
            next_state_s = LIX_DRN_FULL;
          end else if (pop_s) begin
            next_state_s = LIX_DRN_EMPTY;
          end else begin
            next_state_s = LIX_DRN_ONE;
          end
        end
        LIX_DRN_FULL: begin
          // o_rdy is low here, so only a pop can happen: promote S into H.
          if (pop_s) begin
            h_en_s       = 1'b1;
            h_d_s        = s_q_s;
            next_state_s = LIX_DRN_ONE;
          end else begin
            next_state_s = LIX_DRN_FULL;
          end
        end
        default: begin
          next_state_s = LIX_DRN_EMPTY;
        end
      endcase
    end
  end

  // Output decode from the next state, fed to the flag registers.
  always_comb begin
    vld_nx_s = (next_state_s != LIX_DRN_EMPTY);
    rdy_nx_s = (next_state_s != LIX_DRN_FULL);
    cnt_nx_s = lix_drn_cnt(next_state_s);
  end

  lix_dff_en #(.W(W)) u_head (
    .clk (clk_i),
    .rst (rst_i),
    .en  (h_en_s),
    .d   (h_d_s),
    .q   (o_z)
  );

  lix_dff_en #(.W(W)) u_skid (
    .clk (clk_i),
    .rst (rst_i),
    .en  (s_en_s),
    .d   (i_x),
    .q   (s_q_s)
  );

endmodule

// File: tb/tb_lix_reg_drain.sv
// Scoreboard bench for lix_reg_drain: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every downstream handshake.
module tb_lix_reg_drain;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_vld;
  logic        i_en;
  logic [31:0] i_x;
  logic        o_rdy;
  logic        i_flush;
  logic        o_vld;
  logic [31:0] o_z;
  logic        i_rdy;
  logic [1:0]  o_cnt;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  lix_reg_drain #(.W(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_vld   (i_vld),
    .i_en    (i_en),
    .i_x     (i_x),
    .o_rdy   (o_rdy),
    .i_flush (i_flush),
    .o_vld   (o_vld),
    .o_z     (o_z),
    .i_rdy   (i_rdy),
    .o_cnt   (o_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] x, input logic en, input bit accepted);
    i_vld = 1'b1;
    i_en  = en;
    i_x   = x;
    if (accepted) exp_q.push_back(x);
  endtask

  task automatic idle_in();
    i_vld = 1'b0;
    i_en  = 1'b0;
  endtask

  // Monitor: a handshake will occur at the next rising edge (no flush/reset).
  always @(negedge clk_i) begin
    if (!rst_i && !i_flush && o_vld && i_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", o_z, 32'hFFFF_FFFF ^ o_z);
      end else begin
        check("pop_data", o_z, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_i   = 1'b1;
    i_vld   = 1'b0;
    i_en    = 1'b0;
    i_x     = 32'd0;
    i_flush = 1'b0;
    i_rdy   = 1'b0;
    step();
    check("rst_vld", {31'd0, o_vld}, 32'd0);
    check("rst_rdy", {31'd0, o_rdy}, 32'd1);
    check("rst_cnt", {30'd0, o_cnt}, 32'd0);
    check("rst_z",   o_z,            32'd0);
    rst_i = 1'b0;
    step();

    // Streaming at full rate.
    i_rdy = 1'b1;
    offer(32'h1, 1'b1, 1'b1); step();
    check("stream_z1", o_z, 32'h1);
    offer(32'h2, 1'b1, 1'b1); step();
    check("stream_z2", o_z, 32'h2);
    check("stream_cnt2", {30'd0, o_cnt}, 32'd1);
    offer(32'h3, 1'b1, 1'b1); step();
    check("stream_z3", o_z, 32'h3);
    check("stream_cnt3", {30'd0, o_cnt}, 32'd1);
    check("stream_rdy", {31'd0, o_rdy}, 32'd1);
    idle_in(); step();
    check("stream_empty", {30'd0, o_cnt}, 32'd0);

    // Backpressure fills both slots, third offer refused.
    i_rdy = 1'b0;
    offer(32'h10, 1'b1, 1'b1); step();
    offer(32'h20, 1'b1, 1'b1); step();
    check("bp_cnt", {30'd0, o_cnt}, 32'd2);
    check("bp_rdy", {31'd0, o_rdy}, 32'd0);
    check("bp_z",   o_z, 32'h10);
    offer(32'h30, 1'b1, 1'b0); step();
    check("bp_hold_cnt", {30'd0, o_cnt}, 32'd2);
    check("bp_hold_z",   o_z, 32'h10);
    check("bp_hold_vld", {31'd0, o_vld}, 32'd1);
    i_rdy = 1'b1; step();          // pops 0x10, 0x30 still refused
    check("bp_drain_z", o_z, 32'h20);
    check("bp_drain_rdy", {31'd0, o_rdy}, 32'd1);
    exp_q.push_back(32'h30); step(); // 0x30 captured while 0x20 pops
    check("bp_30_z", o_z, 32'h30);
    idle_in(); step();
    check("bp_empty", {30'd0, o_cnt}, 32'd0);

    // Enable gating.
    offer(32'hDEAD, 1'b0, 1'b0); step();
    check("en_gate_vld", {31'd0, o_vld}, 32'd0);
    check("en_gate_cnt", {30'd0, o_cnt}, 32'd0);
    offer(32'hDEAD, 1'b1, 1'b1); step();
    check("en_z", o_z, 32'hDEAD);
    idle_in(); step();

    // Simultaneous push and pop in ONE.
    i_rdy = 1'b0;
    offer(32'h7, 1'b1, 1'b1); step();
    check("pp_z7", o_z, 32'h7);
    i_rdy = 1'b1;
    offer(32'h8, 1'b1, 1'b1); step();
    check("pp_z8", o_z, 32'h8);
    check("pp_cnt", {30'd0, o_cnt}, 32'd1);
    idle_in(); step();

    // Flush in FULL with handshakes pending.
    i_rdy = 1'b0;
    offer(32'h51, 1'b1, 1'b1); step();
    offer(32'h52, 1'b1, 1'b1); step();
    check("fl_full", {30'd0, o_cnt}, 32'd2);
    i_flush = 1'b1; i_rdy = 1'b1;
    offer(32'h53, 1'b1, 1'b0); step();
    exp_q.delete();
    i_flush = 1'b0; idle_in();
    check("fl_cnt", {30'd0, o_cnt}, 32'd0);
    check("fl_vld", {31'd0, o_vld}, 32'd0);
    check("fl_rdy", {31'd0, o_rdy}, 32'd1);

    // Flush in ONE with a real push and pop in the same cycle.
    offer(32'h60, 1'b1, 1'b1); i_rdy = 1'b0; step();
    i_flush = 1'b1; i_rdy = 1'b1;
    offer(32'h61, 1'b1, 1'b0); step();
    exp_q.delete();
    i_flush = 1'b0; idle_in();
    check("fl1_cnt", {30'd0, o_cnt}, 32'd0);
    step();
    check("fl1_stay_empty", {31'd0, o_vld}, 32'd0);

    // Asynchronous reset mid-cycle while FULL.
    i_rdy = 1'b0;
    offer(32'h71, 1'b1, 1'b1); step();
    offer(32'h72, 1'b1, 1'b1); step();
    idle_in();
    check("ar_full", {30'd0, o_cnt}, 32'd2);
    #2 rst_i = 1'b1;
    #1;
    exp_q.delete();
    check("ar_vld", {31'd0, o_vld}, 32'd0);
    check("ar_rdy", {31'd0, o_rdy}, 32'd1);
    check("ar_cnt", {30'd0, o_cnt}, 32'd0);
    check("ar_z",   o_z,            32'd0);
    step();
    rst_i = 1'b0;
    i_rdy = 1'b1;
    offer(32'hA5A5_A5A5, 1'b1, 1'b1); step();
    check("ar_first_z", o_z, 32'hA5A5_A5A5);
    idle_in(); step(); step();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
